// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the five-stage MIPS core.
// Issues one word read at a time over a req/gnt/rvalid handshake, buffers
// {pc, instr} pairs in a small FIFO and hands them to decode with valid/ready.
// Optional feature macro: IFU_ALIGN_CHECK_EN (word-aligns misaligned redirect
// targets and raises a sticky adel_flag).
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        adel_flag
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q;
  logic [31:0]   out_pc;
  logic          outstanding;
  logic          discard;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];

  logic          grant;
  logic          resp;
  logic          push;
  logic          pop;
  logic          out_next;
  logic [31:0]   redirect_pc;

`ifdef IFU_ALIGN_CHECK_EN
  logic misaligned;
  logic adel_q;

  // Misaligned redirect targets are forced onto a word boundary.
  always_comb begin
    misaligned  = (jump_target[1:0] != 2'b00);
    redirect_pc = {jump_target[31:2], 2'b00};
  end

  // Sticky address-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adel_q <= 1'b0;
    end else if (jump_flag && misaligned) begin
      adel_q <= 1'b1;
    end
  end

  // Expose the sticky flag.
  always_comb begin
    adel_flag = adel_q;
  end
`else
  // Redirect target is taken verbatim; no alignment checking.
  always_comb begin
    redirect_pc = jump_target;
    adel_flag   = 1'b0;
  end
`endif

  // Request when no read is pending (or it completes now) and the FIFO has
  // room for every word already committed; a same-cycle pop is not credited.
  always_comb begin
    imem_req  = reset_n && (!outstanding || imem_rvalid) &&
                ((count + CW'(outstanding)) < DEPTH_C);
    imem_addr = pc_q;
    grant     = imem_req && imem_gnt;
    resp      = imem_rvalid && outstanding;
    push      = resp && !discard && !jump_flag;
    pop       = if_valid && id_ready;
    out_next  = grant || (outstanding && !resp);
  end

  // Head of FIFO to decode; zeroed while empty.
  always_comb begin
    if_valid = (count != '0);
    if_pc    = if_valid ? fifo_pc[rd_ptr]    : '0;
    if_instr = if_valid ? fifo_instr[rd_ptr] : '0;
  end

  // Fetch PC, in-flight read tracking and FIFO occupancy; redirect wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      out_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (grant) begin
        outstanding <= 1'b1;
        out_pc      <= pc_q;
      end else if (resp) begin
        outstanding <= 1'b0;
      end

      // A read still in flight after a redirect belongs to the old stream.
      if (jump_flag) begin
        pc_q    <= redirect_pc;
        discard <= out_next;
      end else if (grant) begin
        pc_q    <= pc_q + 32'd4;
        discard <= 1'b0;
      end

      if (jump_flag) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage; contents are only observable through a non-zero count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= out_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the five-stage MIPS core. It holds the architectural fetch PC and issues word reads to instruction memory over a request/grant/response handshake. Returned words are buffered with their PCs in a small FIFO and delivered to decode under a valid/ready handshake. It consumes the redirect pair `jump_flag` / `jump_target` produced by the jump-target unit, which sits directly upstream and drives `jump_target` with its `JumpOffset` result.

## Interface
- `RESET_PC`, default `32'h0000_3000`: fetch PC after reset.
- `DEPTH`, default 4: fetch FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `jump_flag`  in  1  redirect request, sampled each cycle.
- `jump_target`  in  32  redirect PC.
- `imem_req`  out  1  read request.
- `imem_addr`  out  32  read word address.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `if_valid`  out  1  FIFO head valid.
- `if_instr`  out  32  head instruction.
- `if_pc`  out  32  head PC.
- `id_ready`  in  1  decode accepts head.
- `adel_flag`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- State:
  - `pc_q` is the next PC to request.
  - `outstanding` (1 bit) and `out_pc` track the in-flight read.
  - `discard` marks the in-flight response as stale.
  - FIFO of `{pc, instr}` with a `count`.
- At most one read is outstanding at any time.
- `imem_req = reset_n && (!outstanding || imem_rvalid) && (count + outstanding) < DEPTH`. Room is computed from registered `count`; a same-cycle pop is not credited.
- `imem_addr = pc_q`. It may change while `imem_req` is high without grant; the request is not committed until `imem_gnt`.
- Grant (`imem_req && imem_gnt`):
  - `outstanding <= 1`, `out_pc <= pc_q`, `pc_q <= pc_q + 4` (mod 2^32, wraps silently).
  - `discard <= 0` on grant, unless the redirect rule below sets it.
- Response (`imem_rvalid` while `outstanding`):
  - `outstanding <= 0` unless re-granted in the same cycle.
  - If `!discard`, push `{out_pc, imem_rdata}`; otherwise drop it.
  - `imem_rvalid` with `!outstanding` is ignored.
- Pop: `if_valid && id_ready` removes the head.
- Redirect (`jump_flag`), highest priority:
  - FIFO flushed (`count <= 0`) and `pc_q <= jump_target`.
  - Any same-cycle response is dropped.
  - If a read remains outstanding after this cycle, including one granted this same cycle, `discard <= 1`.
  - A same-cycle pop still completes; decode owns that instruction.
- `if_valid = (count != 0)`. `if_instr` / `if_pc` read the head entry and are 0 when empty.

## Timing
- Reset values: `pc_q = RESET_PC`, `count = 0`, `outstanding = 0`, `discard = 0`, `imem_req = 0`, `imem_addr = RESET_PC`, `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `adel_flag = 0`.
- Reset asserted mid-operation clears all state immediately. A response arriving after release is ignored because `outstanding = 0`.
- `imem_req` rises in the first cycle after `reset_n` goes high.
- Latency:
  - Grant at cycle N, earliest `imem_rvalid` at N+1.
  - Entry visible on `if_valid` at the cycle after `imem_rvalid`.
- Redirect in cycle N:
  - `imem_addr = jump_target` at N+1.
  - `if_valid = 0` at N+1.
  - The first target instruction appears at N+3 at best (grant N+1, rvalid N+2).
- Full FIFO (`count == DEPTH`): no request. A push never overflows because room includes `outstanding`.
- Throughput is one instruction per cycle with single-cycle memory, `DEPTH ≥ 3`, and `id_ready` held high.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined:
  - A redirect with `jump_target[1:0] != 0` loads `pc_q <= {jump_target[31:2], 2'b00}`.
  - It also sets `adel_flag`, which is cleared only by reset.
- Not defined:
  - `jump_target` is loaded unmodified, so the low bits propagate to `imem_addr`.
  - `adel_flag` is tied to 0.

## Test plan
- Reset release, memory grants immediately and returns data the next cycle, `id_ready = 1` -> `imem_addr` sequence 0x3000, 0x3004, 0x3008…; `if_pc` / `if_instr` match in order; no gaps after fill.
- `id_ready = 0` for 10 cycles, `DEPTH = 4` -> exactly 4 entries buffered and `imem_req` low. Release gives 4 consecutive pops in order with PCs 0x3000–0x300C.
- `jump_flag` with `jump_target = 0x3100` while a read of 0x3008 is outstanding -> that response is dropped, `if_valid` is 0 for the next cycle, the next `if_pc` is 0x3100.
- `jump_flag` in the same cycle as grant of 0x3004 and as `imem_rvalid` for 0x3000 -> both words are discarded; the next request address is the target.
- `jump_target = 0x3102` -> with `IFU_ALIGN_CHECK_EN`, `imem_addr = 0x3100` and `adel_flag` = 1 and sticky; without it, `imem_addr = 0x3102` and `adel_flag` = 0.
- `reset_n` pulsed low while a read is outstanding and the FIFO holds 2 entries -> all outputs return to reset values asynchronously; a late `imem_rvalid` is ignored; fetch restarts at 0x3000.
